// File: rtl/bram_periph.sv
`default_nettype none
// ============================================================================
// Module   : bram_periph
// Brief    : Bus responder serving CPU reads/writes from on-chip block RAM.
// Revision : 1.0
// ============================================================================
module bram_periph #(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        DATA_W    = 8,
  parameter int unsigned        RD_LAT    = 2,
  parameter logic [ADDR_W-1:0]  HOLE_BASE = 16'hFF00,
  parameter string              INIT_FILE = ""
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_ready,
  output logic              o_busy
);

  localparam int unsigned c_DEPTH    = 1 << ADDR_W;
  localparam logic [1:0]  c_IDLE      = 2'd0;
  localparam logic [1:0]  c_WRITE_ACK = 2'd1;
  localparam logic [1:0]  c_READ_WAIT = 2'd2;
  localparam logic [1:0]  c_READ_ACK  = 2'd3;
  // READ_WAIT counts down to zero, then the RAM is read on the following edge.
  localparam logic [1:0]  c_CNT_INIT  = (RD_LAT >= 2) ? 2'(RD_LAT - 2) : 2'd0;

  logic [DATA_W-1:0] mem [0:c_DEPTH-1];
  logic [DATA_W-1:0] mem_rdata_q;

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              stb_q, stb_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              zero_q, zero_d;

  logic              w_accept;
  logic              w_mem_we;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_accept  = (state_q == c_IDLE) && i_cs && i_stb && !stb_q;
  assign w_rd_addr = (state_q == c_IDLE) ? i_addr : addr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    ready_d  = 1'b0;
    w_mem_we = 1'b0;
    w_rd_en  = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          busy_d = 1'b1;
          if (i_we) begin
            w_mem_we = (i_addr < HOLE_BASE);
            ready_d  = 1'b1;
            state_d  = c_WRITE_ACK;
          end else if (RD_LAT <= 1) begin
            w_rd_en = 1'b1;
            ready_d = 1'b1;
            state_d = c_READ_ACK;
          end else begin
            cnt_d   = c_CNT_INIT;
            state_d = c_READ_WAIT;
          end
        end
      end
      c_READ_WAIT: begin
        if (cnt_q == 2'd0) begin
          w_rd_en = 1'b1;
          ready_d = 1'b1;
          state_d = c_READ_ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      c_WRITE_ACK, c_READ_ACK: begin
        busy_d  = 1'b0;
        state_d = c_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = c_IDLE;
      end
    endcase
  end

  always_comb begin
    stb_d  = i_stb;
    addr_d = w_accept ? i_addr : addr_q;
    // Hole reads return zero by masking the RAM output rather than muxing data.
    zero_d = w_rd_en ? (w_rd_addr >= HOLE_BASE) : zero_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= c_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      stb_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      stb_q   <= stb_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      zero_q  <= zero_d;
    end
  end

  // Reset deliberately leaves the array and its read register untouched.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      mem[i_addr] <= i_data;
    end
    if (w_rd_en) begin
      mem_rdata_q <= mem[w_rd_addr];
    end
  end

  assign o_data       = zero_q ? '0 : mem_rdata_q;
  assign o_data_ready = ready_q;
  assign o_busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_periph
// Brief    : Self-checking bench for bram_periph at read latencies 2 and 4.
// Revision : 1.0
// ============================================================================
module tb_bram_periph;

  localparam logic [15:0] HOLE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  od [2];
  logic        rdy [2];
  logic        bsy [2];

  always #5 clk = ~clk;

  bram_periph #(.RD_LAT(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_stb(stb), .i_we(we),
    .i_addr(addr), .i_data(wdata),
    .o_data(od[0]), .o_data_ready(rdy[0]), .o_busy(bsy[0])
  );

  bram_periph #(.RD_LAT(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_stb(stb), .i_we(we),
    .i_addr(addr), .i_data(wdata),
    .o_data(od[1]), .o_data_ready(rdy[1]), .o_busy(bsy[1])
  );

  // Transaction-level reference: each accepted request occupies [acc, ack] in edge numbers.
  bit [7:0] mmem [2][65536];
  int       cyc = 0;
  int       m_acc [2];
  int       m_ack [2];
  bit       m_isrd [2];
  bit [7:0] m_rdval [2];
  bit [7:0] m_dat [2];
  bit       prev_stb = 1'b0;
  int       ack_cnt [2];
  logic [7:0] ack_dat [2];
  int       n_tests = 0;
  int       n_fail = 0;

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl [14];

  logic [15:0] pool [8];

  function automatic int lat(int k);
    return (k == 0) ? 2 : 4;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k]  = -100;
      m_ack[k]  = -100;
      m_isrd[k] = 1'b0;
      m_dat[k]  = 8'h00;
    end
    prev_stb = 1'b0;
  endfunction

  function automatic void model_edge(int k);
    if (cyc >= m_ack[k] + 2 && cs && stb && !prev_stb) begin
      m_acc[k] = cyc;
      if (we) begin
        if (addr < HOLE) mmem[k][addr] = wdata;
        m_ack[k]  = cyc;
        m_isrd[k] = 1'b0;
      end else begin
        m_ack[k]    = cyc + lat(k) - 1;
        m_rdval[k]  = (addr >= HOLE) ? 8'h00 : mmem[k][addr];
        m_isrd[k]   = 1'b1;
      end
    end
    if (cyc == m_ack[k] && m_isrd[k]) m_dat[k] = m_rdval[k];
  endfunction

  function automatic bit model_idle();
    return (cyc >= m_ack[0] + 2) && (cyc >= m_ack[1] + 2);
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < 2; k++) model_edge(k);
    end
    prev_stb = rst ? 1'b0 : stb;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(cyc == m_ack[k]));
      chk($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(cyc >= m_acc[k] && cyc <= m_ack[k]));
      chk($sformatf("data[%0d]", k), 32'(od[k]), 32'(m_dat[k]));
      if (rdy[k] === 1'b1) begin
        ack_cnt[k]++;
        ack_dat[k] = od[k];
      end
    end
    cyc++;
  endtask

  task automatic apply_reset(int cycles);
    rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready[%0d]", k), 32'(rdy[k]), 32'd0);
      chk($sformatf("rst_busy[%0d]", k), 32'(bsy[k]), 32'd0);
      chk($sformatf("rst_data[%0d]", k), 32'(od[k]), 32'd0);
    end
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 12 && !model_idle(); i++) step();
    step();
  endtask

  task automatic clear_acks();
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
  endtask

  task automatic transact(bit w, logic [15:0] a, logic [7:0] d, int hold);
    clear_acks();
    cs = 1'b1; we = w; addr = a; wdata = d; stb = 1'b1;
    repeat (hold) step();
    stb = 1'b0; cs = 1'b0;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 16'h1234, 8'hA5, 8'h00};
    tbl[1]  = '{1'b0, 16'h1234, 8'h00, 8'hA5};
    tbl[2]  = '{1'b1, 16'h0010, 8'h3C, 8'h00};
    tbl[3]  = '{1'b1, 16'h0F10, 8'h5A, 8'h00};
    tbl[4]  = '{1'b1, 16'hFF10, 8'h77, 8'h00};
    tbl[5]  = '{1'b0, 16'hFF10, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, 16'h0F10, 8'h00, 8'h5A};
    tbl[7]  = '{1'b1, 16'hFEFF, 8'h81, 8'h00};
    tbl[8]  = '{1'b0, 16'hFEFF, 8'h00, 8'h81};
    tbl[9]  = '{1'b1, 16'hFF00, 8'h11, 8'h00};
    tbl[10] = '{1'b0, 16'hFF00, 8'h00, 8'h00};
    tbl[11] = '{1'b0, 16'hFFFF, 8'h00, 8'h00};
    tbl[12] = '{1'b1, 16'h0000, 8'hC3, 8'h00};
    tbl[13] = '{1'b0, 16'h0010, 8'h00, 8'h3C};
    pool = '{16'h1234, 16'h0010, 16'h0F10, 16'hFEFF,
             16'hFF10, 16'hFF00, 16'hFFFF, 16'h0000};

    #2;
    apply_reset(2);
    repeat (10) step();

    for (int i = 0; i < 14; i++) begin
      transact(tbl[i].w, tbl[i].a, tbl[i].d, 2);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("vec%0d_acks[%0d]", i, k), 32'(ack_cnt[k]), 32'd1);
        if (!tbl[i].w)
          chk($sformatf("vec%0d_rdata[%0d]", i, k), 32'(ack_dat[k]), 32'(tbl[i].exp));
      end
    end

    // Held strobe: one access only.
    transact(1'b0, 16'h0010, 8'h00, 8);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("held_acks[%0d]", k), 32'(ack_cnt[k]), 32'd1);
      chk($sformatf("held_rdata[%0d]", k), 32'(ack_dat[k]), 32'h3C);
    end

    // A second rise while busy is dropped, not replayed.
    clear_acks();
    cs = 1'b1; we = 1'b0; addr = 16'h1234; stb = 1'b1;
    step();
    stb = 1'b0; step();
    stb = 1'b1; repeat (5) step();
    stb = 1'b0; cs = 1'b0;
    settle();
    for (int k = 0; k < 2; k++)
      chk($sformatf("drop_acks[%0d]", k), 32'(ack_cnt[k]), 32'd1);

    // Chip select low: ignored.
    clear_acks();
    cs = 1'b0; we = 1'b0; addr = 16'h0010; stb = 1'b1;
    repeat (4) step();
    stb = 1'b0; step();
    for (int k = 0; k < 2; k++)
      chk($sformatf("cslow_acks[%0d]", k), 32'(ack_cnt[k]), 32'd0);

    // Chip select dropped after acceptance: still acknowledged.
    clear_acks();
    cs = 1'b1; we = 1'b0; addr = 16'h0F10; stb = 1'b1;
    step();
    cs = 1'b0;
    settle();
    stb = 1'b0; step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("csdrop_acks[%0d]", k), 32'(ack_cnt[k]), 32'd1);
      chk($sformatf("csdrop_rdata[%0d]", k), 32'(ack_dat[k]), 32'h5A);
    end

    // Reset at T+2 of a read: the latency-4 instance must never acknowledge.
    clear_acks();
    cs = 1'b1; we = 1'b0; addr = 16'h0010; stb = 1'b1;
    step();
    cs = 1'b0; stb = 1'b0;
    step();
    step();
    apply_reset(2);
    chk("midrst_acks[1]", 32'(ack_cnt[1]), 32'd0);
    step();
    transact(1'b0, 16'h1234, 8'h00, 2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("postrst_acks[%0d]", k), 32'(ack_cnt[k]), 32'd1);
      chk($sformatf("postrst_rdata[%0d]", k), 32'(ack_dat[k]), 32'hA5);
    end

    // Randomized traffic over written and hole addresses.
    for (int i = 0; i < 800; i++) begin
      stb   = ($urandom_range(0, 2) != 0);
      cs    = ($urandom_range(0, 7) != 0);
      we    = 1'($urandom_range(0, 1));
      addr  = pool[$urandom_range(0, 7)];
      wdata = 8'($urandom);
      step();
    end
    stb = 1'b0; cs = 1'b0;
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
